instruction_fetch_unit: RTL and testbench

Fetch stage that sits directly upstream of the instruction ROM and feeds the decode stage. It holds the PC and drives the ROM address. It captures the returned word, together with PC and PC+4, into an IF/ID register that uses a valid/ready handshake. It also handles branch/jump redirects with a flush, and traps misaligned or out-of-range fetches into a sticky fault state.

---
 rtl/instruction_fetch_unit_if.sv | 46 ++++
 rtl/instruction_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: ROM port, execute redirect, IF/ID handshake, status.
// master = fetch unit side; slave = ROM / execute / decode side.
interface instruction_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] issued_count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_target,
    input  id_ready,
    output id_valid,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output fetch_fault,
    output fault_pc,
    output issued_count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_target,
    output id_ready,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  fetch_fault,
    input  fault_pc,
    input  issued_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, ROM addressing, IF/ID register with valid/ready, redirects.
// Ports: clk, rst (sync, active-high), bus (instruction_fetch_unit_if.master).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input logic                            clk,
  input logic                            rst,
  instruction_fetch_unit_if.master       bus
);

  typedef enum logic {
    RUN,
    FAULT
  } state_e;

  // One bit wider than the PC so IMEM_WORDS*4 cannot overflow.
  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

  function automatic logic is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({1'b0, a} < IMEM_BYTES);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] issued_q, issued_d;

  logic xfer;
  logic fire;

  assign xfer = id_valid_q && bus.id_ready;
  assign fire = !id_valid_q || bus.id_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    fault_pc_d    = fault_pc_q;
    issued_d      = issued_q;

    if (bus.redirect_valid) begin
      // Flush wins over any handshake this cycle.
      id_valid_d = 1'b0;
      pc_d       = bus.redirect_target;
      if (is_legal(bus.redirect_target)) begin
        state_d = RUN;
      end else begin
        state_d    = FAULT;
        fault_pc_d = bus.redirect_target;
      end
    end else begin
      if (xfer) begin
        issued_d = issued_q + 32'd1;
      end
      unique case (state_q)
        RUN: begin
          if (fire) begin
            if (is_legal(pc_q)) begin
              id_valid_d    = 1'b1;
              id_instr_d    = bus.imem_rdata;
              id_pc_d       = pc_q;
              id_pc_plus4_d = pc_q + 32'd4;
              pc_d          = pc_q + 32'd4;
            end else begin
              state_d    = FAULT;
              fault_pc_d = pc_q;
              id_valid_d = 1'b0;
            end
          end
        end
        FAULT: begin
          id_valid_d = 1'b0;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'h0;
      id_pc_plus4_q <= 32'h0;
      fault_pc_q    <= 32'h0;
      issued_q      <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      fault_pc_q    <= fault_pc_d;
      issued_q      <= issued_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.id_valid     = id_valid_q;
  assign bus.id_instr     = id_valid_q ? id_instr_q : NOP_INSTR;
  assign bus.id_pc        = id_pc_q;
  assign bus.id_pc_plus4  = id_pc_plus4_q;
  assign bus.fetch_fault  = (state_q == FAULT);
  assign bus.fault_pc     = fault_pc_q;
  assign bus.issued_count = issued_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 64-word ROM model.
// ROM: word0=0x493, word1=0x413, word i (i>=2) = 0x1000_0000 + i.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  logic [31:0] rom [64];

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC   (32'h0),
    .IMEM_WORDS (64),
    .NOP_INSTR  (32'h13)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = (bus.imem_addr < 32'd256)
                        ? rom[bus.imem_addr[7:2]]
                        : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {valid, fault, id_pc, id_instr, issued}
  task automatic chk(input string nm,
                     input logic v, input logic f,
                     input logic [31:0] pc,
                     input logic [31:0] ins,
                     input logic [31:0] iss);
    total++;
    if ({bus.id_valid, bus.fetch_fault, bus.id_pc,
         bus.id_instr, bus.issued_count}
        !== {v, f, pc, ins, iss}) begin
      $display("FAIL %s got v=%b f=%b pc=%h ins=%h iss=%0d want v=%b f=%b pc=%h ins=%h iss=%0d",
               nm, bus.id_valid, bus.fetch_fault, bus.id_pc,
               bus.id_instr, bus.issued_count, v, f, pc, ins, iss);
    end else begin
      passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    step();
    step();
    total++;
    if ({bus.id_valid, bus.id_instr, bus.id_pc,
         bus.id_pc_plus4, bus.fetch_fault, bus.fault_pc,
         bus.issued_count, bus.imem_addr}
        !== {1'b0, 32'h13, 32'h0, 32'h0, 1'b0,
             32'h0, 32'h0, 32'h0}) begin
      $display("FAIL reset got v=%b ins=%h pc=%h p4=%h f=%b fpc=%h iss=%0d a=%h",
               bus.id_valid, bus.id_instr, bus.id_pc,
               bus.id_pc_plus4, bus.fetch_fault, bus.fault_pc,
               bus.issued_count, bus.imem_addr);
    end else begin
      passed++;
    end
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    bus.id_ready = 1'b1;
    step();
    chk("seq0", 1, 0, 32'h0, 32'h493, 0);
    step();
    chk("seq1", 1, 0, 32'h4, 32'h413, 1);
    total++;
    if (bus.id_pc_plus4 !== 32'h8) begin
      $display("FAIL seq1_plus4 got %h want %h",
               bus.id_pc_plus4, 32'h8);
    end else begin
      passed++;
    end
    step();
    chk("seq2", 1, 0, 32'h8, 32'h1000_0002, 2);
  endtask

  task automatic test_stall();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall", 1, 0, 32'h8, 32'h1000_0002, 2);
      total++;
      if (bus.imem_addr !== 32'hC) begin
        $display("FAIL stall_addr got %h want %h",
                 bus.imem_addr, 32'hC);
      end else begin
        passed++;
      end
    end
    bus.id_ready = 1'b1;
    step();
    chk("unstall", 1, 0, 32'hC, 32'h1000_0003, 3);
  endtask

  task automatic test_redirect_stall();
    for (int i = 0; i < 5; i++) step();
    chk("pre_redir", 1, 0, 32'h20, 32'h1000_0008, 8);
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'hC;
    step();
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b1;
    chk("redir_flush", 0, 0, 32'h20, 32'h13, 8);
    total++;
    if (bus.imem_addr !== 32'hC) begin
      $display("FAIL redir_addr got %h want %h",
               bus.imem_addr, 32'hC);
    end else begin
      passed++;
    end
    step();
    chk("redir_issue", 1, 0, 32'hC, 32'h1000_0003, 8);
  endtask

  task automatic test_redirect_cancel();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    chk("cancel_flush", 0, 0, 32'hC, 32'h13, 8);
    step();
    chk("cancel_issue", 1, 0, 32'h40, 32'h1000_0010, 8);
    total++;
    if (bus.id_pc_plus4 !== 32'h44) begin
      $display("FAIL cancel_plus4 got %h want %h",
               bus.id_pc_plus4, 32'h44);
    end else begin
      passed++;
    end
    step();
    chk("cancel_next", 1, 0, 32'h44, 32'h1000_0011, 9);
  endtask

  task automatic test_fault();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h22;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("fault_hold", 0, 1, 32'h44, 32'h13, 9);
      total++;
      if ({bus.fault_pc, bus.imem_addr} !== {32'h22, 32'h22}) begin
        $display("FAIL fault_pc got fpc=%h a=%h want %h",
                 bus.fault_pc, bus.imem_addr, 32'h22);
      end else begin
        passed++;
      end
      step();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    chk("fault_exit", 0, 0, 32'h44, 32'h13, 9);
    total++;
    if (bus.fault_pc !== 32'h22) begin
      $display("FAIL fault_pc_keep got %h want %h",
               bus.fault_pc, 32'h22);
    end else begin
      passed++;
    end
    step();
    chk("fault_reissue", 1, 0, 32'h0, 32'h493, 9);
  endtask

  task automatic test_run_off_end();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'hF8;
    step();
    bus.redirect_valid = 1'b0;
    chk("end_flush", 0, 0, 32'h0, 32'h13, 9);
    step();
    chk("end_f8", 1, 0, 32'hF8, 32'h1000_003E, 9);
    step();
    chk("end_fc", 1, 0, 32'hFC, 32'h1000_003F, 10);
    step();
    chk("end_fault", 0, 1, 32'hFC, 32'h13, 11);
    total++;
    if (bus.fault_pc !== 32'h100) begin
      $display("FAIL end_fault_pc got %h want %h",
               bus.fault_pc, 32'h100);
    end else begin
      passed++;
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step();
    chk("rst_fault", 0, 0, 32'h0, 32'h13, 0);
    total++;
    if ({bus.fault_pc, bus.imem_addr} !== 64'h0) begin
      $display("FAIL rst_fault_pc got fpc=%h a=%h want 0",
               bus.fault_pc, bus.imem_addr);
    end else begin
      passed++;
    end
    rst = 1'b0;
    step();
    chk("rst_first", 1, 0, 32'h0, 32'h493, 0);
    step();
    step();
    chk("rst_run", 1, 0, 32'h8, 32'h1000_0002, 2);
    bus.id_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rst_stall", 0, 0, 32'h0, 32'h13, 0);
    total++;
    if ({bus.id_pc_plus4, bus.imem_addr} !== 64'h0) begin
      $display("FAIL rst_stall_p4 got p4=%h a=%h want 0",
               bus.id_pc_plus4, bus.imem_addr);
    end else begin
      passed++;
    end
    rst = 1'b0;
    bus.id_ready = 1'b1;
    step();
    chk("rst_refetch", 1, 0, 32'h0, 32'h493, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
    rom[0] = 32'h0000_0493;
    rom[1] = 32'h0000_0413;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_redirect_cancel();
    test_fault();
    test_run_off_end();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
